// File: rtl/vram_rd_arbiter.sv
// Two-master AXI read-port arbiter for VRAM: display (M0) has priority, the secondary reader (M1) is
// protected by a starvation counter. Optional grant statistics are enabled with VRAMARB_STAT_EN.
module vram_rd_arbiter #(
   parameter int DATA_W     = 64,
   parameter int STARVE_MAX = 8,
   parameter int CNT_W      = 4
) (
   input  logic              ACLK,
   input  logic              ARST,
`ifdef VRAMARB_STAT_EN
   input  logic              STAT_CLR,
   output logic [15:0]       GNT0_CNT,
   output logic [15:0]       GNT1_CNT,
`endif
   input  logic [31:0]       M0_ARADDR,
   input  logic              M0_ARVALID,
   output logic              M0_ARREADY,
   output logic [DATA_W-1:0] M0_RDATA,
   output logic              M0_RLAST,
   output logic              M0_RVALID,
   input  logic              M0_RREADY,
   input  logic [31:0]       M1_ARADDR,
   input  logic              M1_ARVALID,
   output logic              M1_ARREADY,
   output logic [DATA_W-1:0] M1_RDATA,
   output logic              M1_RLAST,
   output logic              M1_RVALID,
   input  logic              M1_RREADY,
   output logic [31:0]       S_ARADDR,
   output logic              S_ARVALID,
   input  logic              S_ARREADY,
   input  logic [DATA_W-1:0] S_RDATA,
   input  logic              S_RLAST,
   input  logic              S_RVALID,
   output logic              S_RREADY
);

   localparam logic [2:0]       ST_IDLE    = 3'b001;
   localparam logic [2:0]       ST_ADDR    = 3'b010;
   localparam logic [2:0]       ST_DATA    = 3'b100;
   localparam logic [CNT_W-1:0] STARVE_LIM = CNT_W'(STARVE_MAX);

   logic [2:0]       state_r, state_nxt_s;
   logic             owner_r, owner_nxt_s;
   logic [CNT_W-1:0] starve_cnt_r, starve_nxt_s;
   logic             in_addr_s, in_data_s;
   logic             sel_arvalid_s, sel_rready_s;
   logic             ar_hs_s, last_hs_s;

   // Handshakes are suppressed during reset so nothing escapes while ARST is being sampled.
   assign in_addr_s     = (state_r == ST_ADDR) && !ARST;
   assign in_data_s     = (state_r == ST_DATA) && !ARST;
   assign sel_arvalid_s = owner_r ? M1_ARVALID : M0_ARVALID;
   assign sel_rready_s  = owner_r ? M1_RREADY : M0_RREADY;
   assign ar_hs_s       = in_addr_s && sel_arvalid_s && S_ARREADY;
   assign last_hs_s     = in_data_s && S_RVALID && sel_rready_s && S_RLAST;

   // State, owner and starvation counter registers
   always_ff @(posedge ACLK) begin
      if (ARST) begin
         state_r      <= ST_IDLE;
         owner_r      <= 1'b0;
         starve_cnt_r <= {CNT_W{1'b0}};
      end else begin
         state_r      <= state_nxt_s;
         owner_r      <= owner_nxt_s;
         starve_cnt_r <= starve_nxt_s;
      end
   end

   // Next-state and arbitration
   always_comb begin
      state_nxt_s  = state_r;
      owner_nxt_s  = owner_r;
      starve_nxt_s = starve_cnt_r;
      case (state_r)
         ST_IDLE: begin
            if (M0_ARVALID && (!M1_ARVALID || (starve_cnt_r < STARVE_LIM))) begin
               state_nxt_s = ST_ADDR;
               owner_nxt_s = 1'b0;
               // M0 only wins a contested grant below the limit, so this saturates at STARVE_LIM
               if (M1_ARVALID) begin
                  starve_nxt_s = starve_cnt_r + CNT_W'(1);
               end else begin
                  starve_nxt_s = starve_cnt_r;
               end
            end else if (M1_ARVALID) begin
               state_nxt_s  = ST_ADDR;
               owner_nxt_s  = 1'b1;
               starve_nxt_s = {CNT_W{1'b0}};
            end else begin
               state_nxt_s = ST_IDLE;
            end
         end
         ST_ADDR: begin
            if (ar_hs_s) begin
               state_nxt_s = ST_DATA;
            end else begin
               state_nxt_s = ST_ADDR;
            end
         end
         ST_DATA: begin
            if (last_hs_s) begin
               state_nxt_s = ST_IDLE;
            end else begin
               state_nxt_s = ST_DATA;
            end
         end
         default: begin
            state_nxt_s  = ST_IDLE;
            owner_nxt_s  = 1'b0;
            starve_nxt_s = {CNT_W{1'b0}};
         end
      endcase
   end

   // Channel routing to and from the granted master
   always_comb begin
      S_ARADDR   = owner_r ? M1_ARADDR : M0_ARADDR;
      S_ARVALID  = in_addr_s && sel_arvalid_s;
      M0_ARREADY = in_addr_s && !owner_r && S_ARREADY;
      M1_ARREADY = in_addr_s && owner_r && S_ARREADY;
      S_RREADY   = in_data_s && sel_rready_s;
      M0_RVALID  = in_data_s && !owner_r && S_RVALID;
      M1_RVALID  = in_data_s && owner_r && S_RVALID;
      M0_RLAST   = in_data_s && !owner_r && S_RLAST;
      M1_RLAST   = in_data_s && owner_r && S_RLAST;
      M0_RDATA   = (in_data_s && !owner_r) ? S_RDATA : {DATA_W{1'b0}};
      M1_RDATA   = (in_data_s && owner_r) ? S_RDATA : {DATA_W{1'b0}};
   end

`ifdef VRAMARB_STAT_EN
   logic [15:0] gnt0_cnt_r, gnt1_cnt_r;

   // Saturating per-master grant counters
   always_ff @(posedge ACLK) begin
      if (ARST || STAT_CLR) begin
         gnt0_cnt_r <= 16'h0000;
         gnt1_cnt_r <= 16'h0000;
      end else begin
         if (ar_hs_s && !owner_r && (gnt0_cnt_r != 16'hFFFF)) begin
            gnt0_cnt_r <= gnt0_cnt_r + 16'h0001;
         end else begin
            gnt0_cnt_r <= gnt0_cnt_r;
         end
         if (ar_hs_s && owner_r && (gnt1_cnt_r != 16'hFFFF)) begin
            gnt1_cnt_r <= gnt1_cnt_r + 16'h0001;
         end else begin
            gnt1_cnt_r <= gnt1_cnt_r;
         end
      end
   end

   assign GNT0_CNT = gnt0_cnt_r;
   assign GNT1_CNT = gnt1_cnt_r;
`endif

endmodule

// File: tb/tb_vram_rd_arbiter.sv
// Scoreboard bench for vram_rd_arbiter: random masters and VRAM model, transaction-level reference
// model predicting grants and returned beats; a separate monitor compares the DUT outputs.
module tb_vram_rd_arbiter;

   localparam int DATA_W     = 64;
   localparam int STARVE_MAX = 8;

   typedef struct { logic own; logic [31:0] addr; } ar_t;
   typedef struct { logic own; logic [63:0] data; logic last; } beat_t;

   logic              ACLK = 1'b0;
   logic              ARST = 1'b1;
   logic [31:0]       M0_ARADDR = 32'h0, M1_ARADDR = 32'h0, S_ARADDR;
   logic              M0_ARVALID = 1'b0, M1_ARVALID = 1'b0, M0_ARREADY, M1_ARREADY;
   logic [DATA_W-1:0] M0_RDATA, M1_RDATA, S_RDATA = '0;
   logic              M0_RLAST, M1_RLAST, M0_RVALID, M1_RVALID;
   logic              M0_RREADY = 1'b0, M1_RREADY = 1'b0;
   logic              S_ARVALID, S_ARREADY = 1'b0, S_RLAST = 1'b0, S_RVALID = 1'b0, S_RREADY;
`ifdef VRAMARB_STAT_EN
   logic              STAT_CLR = 1'b0;
   logic [15:0]       GNT0_CNT, GNT1_CNT;
`endif

   vram_rd_arbiter #(.DATA_W(DATA_W), .STARVE_MAX(STARVE_MAX), .CNT_W(4)) dut (
      .ACLK(ACLK), .ARST(ARST),
`ifdef VRAMARB_STAT_EN
      .STAT_CLR(STAT_CLR), .GNT0_CNT(GNT0_CNT), .GNT1_CNT(GNT1_CNT),
`endif
      .M0_ARADDR(M0_ARADDR), .M0_ARVALID(M0_ARVALID), .M0_ARREADY(M0_ARREADY),
      .M0_RDATA(M0_RDATA), .M0_RLAST(M0_RLAST), .M0_RVALID(M0_RVALID), .M0_RREADY(M0_RREADY),
      .M1_ARADDR(M1_ARADDR), .M1_ARVALID(M1_ARVALID), .M1_ARREADY(M1_ARREADY),
      .M1_RDATA(M1_RDATA), .M1_RLAST(M1_RLAST), .M1_RVALID(M1_RVALID), .M1_RREADY(M1_RREADY),
      .S_ARADDR(S_ARADDR), .S_ARVALID(S_ARVALID), .S_ARREADY(S_ARREADY),
      .S_RDATA(S_RDATA), .S_RLAST(S_RLAST), .S_RVALID(S_RVALID), .S_RREADY(S_RREADY)
   );

   always #5 ACLK = ~ACLK;

   int n_chk = 0, n_fail = 0;
   int m0_beats = 0, m1_beats = 0;
   ar_t   ar_q[$];
   beat_t beat_q[$];
   bit    gnt_log[$];

   // stimulus knobs (percent probabilities)
   int p_req0 = 0, p_req1 = 0, p_ar = 100, p_rv = 100, p_rr = 100;
   logic rst_req = 1'b1;

   // VRAM model state
   logic        sl_active = 1'b0;
   logic [31:0] sl_addr = 32'h0;
   int          sl_beat = 0;

   // reference model state
   int   ph = 0;
   logic own = 1'b0;
   int   starve = 0;
   logic [31:0] cur_addr = 32'h0;
   int   g0 = 0, g1 = 0;

   function automatic int burst_len(input logic [31:0] a);
      return 8 - int'(a[4:2]);
   endfunction

   function automatic logic [63:0] mem_word(input logic [31:0] a, input int b);
      return {a ^ 32'hA5A5_5A5A, 32'(b)};
   endfunction

   task automatic chk(input string nm, input logic [95:0] act, input logic [95:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   task automatic fail_now(input string nm);
      n_chk++;
      n_fail++;
      $display("FAIL %s: event with no expected transaction", nm);
   endtask

   // Reference model: arbitration rules and transaction phases, evaluated on stable pre-edge values.
   always @(negedge ACLK) begin
      if (ARST || ph == 0) begin
         chk("idle_quiet", {S_ARVALID, S_RREADY, M0_ARREADY, M1_ARREADY, M0_RVALID, M1_RVALID}, 6'b0);
      end else if (ph == 1) begin
         chk("addr_no_r", {S_RREADY, M0_RVALID, M1_RVALID}, 3'b0);
         chk("addr_arvalid", S_ARVALID, own ? M1_ARVALID : M0_ARVALID);
      end else begin
         chk("data_no_ar", {S_ARVALID, M0_ARREADY, M1_ARREADY}, 3'b0);
         chk("data_rready", S_RREADY, own ? M1_RREADY : M0_RREADY);
      end
      if (ARST) begin
         ph = 0; starve = 0; g0 = 0; g1 = 0;
         ar_q.delete();
         beat_q.delete();
      end else if (ph == 0) begin
         if (M0_ARVALID && (!M1_ARVALID || starve < STARVE_MAX)) begin
            own = 1'b0; cur_addr = M0_ARADDR; ph = 1;
            if (M1_ARVALID) starve++;
            ar_q.push_back('{1'b0, M0_ARADDR});
         end else if (M1_ARVALID) begin
            own = 1'b1; cur_addr = M1_ARADDR; ph = 1; starve = 0;
            ar_q.push_back('{1'b1, M1_ARADDR});
         end
      end else if (ph == 1) begin
         if ((own ? M1_ARVALID : M0_ARVALID) && S_ARREADY) begin
            ph = 2;
            if (own) g1++; else g0++;
            for (int i = 0; i < burst_len(cur_addr); i++)
               beat_q.push_back('{own, mem_word(cur_addr, i), (i == burst_len(cur_addr) - 1)});
         end
      end else begin
         if (S_RVALID && (own ? M1_RREADY : M0_RREADY) && S_RLAST) ph = 0;
      end
   end

   // Monitor: pops expectations whenever the DUT presents a handshake.
   always @(negedge ACLK) begin
      if (!ARST) begin
         ar_t   ea;
         beat_t eb;
         if (S_ARVALID && S_ARREADY) begin
            if (ar_q.size() == 0) fail_now("ar_unexpected");
            else begin
               ea = ar_q.pop_front();
               chk("ar_addr", S_ARADDR, ea.addr);
               chk("ar_ready", {M1_ARREADY, M0_ARREADY}, ea.own ? 2'b10 : 2'b01);
               gnt_log.push_back(M1_ARREADY);
            end
         end
         if (M0_RVALID && M1_RVALID) fail_now("both_rvalid");
         if (M0_RVALID && M0_RREADY) begin
            m0_beats++;
            if (beat_q.size() == 0) fail_now("m0_beat_unexpected");
            else begin
               eb = beat_q.pop_front();
               chk("m0_beat", {eb.own, M0_RLAST, M0_RDATA}, {1'b0, eb.last, eb.data});
            end
         end
         if (M1_RVALID && M1_RREADY) begin
            m1_beats++;
            if (beat_q.size() == 0) fail_now("m1_beat_unexpected");
            else begin
               eb = beat_q.pop_front();
               chk("m1_beat", {eb.own, M1_RLAST, M1_RDATA}, {1'b1, eb.last, eb.data});
            end
         end
         if (M0_RVALID) chk("m1_nonowner_zero", {M1_RLAST, M1_RDATA}, 65'b0);
         if (M1_RVALID) chk("m0_nonowner_zero", {M0_RLAST, M0_RDATA}, 65'b0);
      end
   end

   // One clock of master/VRAM behaviour: sample handshakes pre-edge, drive new values after the edge.
   task automatic step();
      logic hs0, hs1, sar, srh;
      logic [31:0] sa;
      @(negedge ACLK);
      hs0 = M0_ARVALID & M0_ARREADY;
      hs1 = M1_ARVALID & M1_ARREADY;
      sar = S_ARVALID & S_ARREADY;
      sa  = S_ARADDR;
      srh = sl_active & S_RVALID & S_RREADY;
      @(posedge ACLK);
      #1;
      if (ARST) begin
         M0_ARVALID = 1'b0; M1_ARVALID = 1'b0; sl_active = 1'b0;
      end else begin
         if (hs0) M0_ARVALID = 1'b0;
         if (hs1) M1_ARVALID = 1'b0;
         if (sar) begin
            sl_active = 1'b1; sl_addr = sa; sl_beat = 0;
         end else if (srh) begin
            if (sl_beat == burst_len(sl_addr) - 1) sl_active = 1'b0;
            else sl_beat++;
         end
      end
      ARST = rst_req;
      if (!rst_req) begin
         if (!M0_ARVALID && int'($urandom_range(99)) < p_req0) begin
            M0_ARVALID = 1'b1; M0_ARADDR = $urandom & 32'hFFFF_FFFC;
         end
         if (!M1_ARVALID && int'($urandom_range(99)) < p_req1) begin
            M1_ARVALID = 1'b1; M1_ARADDR = $urandom & 32'hFFFF_FFFC;
         end
      end
      S_ARREADY = int'($urandom_range(99)) < p_ar;
      if (sl_active) begin
         S_RVALID = int'($urandom_range(99)) < p_rv;
         S_RDATA  = mem_word(sl_addr, sl_beat);
         S_RLAST  = (sl_beat == burst_len(sl_addr) - 1);
      end else begin
         S_RVALID = int'($urandom_range(99)) < 20;
         S_RDATA  = {$urandom, $urandom};
         S_RLAST  = $urandom_range(1);
      end
      M0_RREADY = int'($urandom_range(99)) < p_rr;
      M1_RREADY = int'($urandom_range(99)) < p_rr;
   endtask

   task automatic do_reset(input int n);
      rst_req = 1'b1;
      repeat (n) step();
      rst_req = 1'b0;
      step();
   endtask

   initial begin
      int base, guard;

      // single M0 burst of 8 beats
      do_reset(3);
      M0_ARVALID = 1'b1; M0_ARADDR = 32'h0010_0000;
      repeat (25) step();
      chk("m0_only_beats", 32'(m0_beats), 32'd8);
      chk("m0_only_no_m1", 32'(m1_beats), 32'd0);

      // randomized traffic with backpressure on every channel
      p_req0 = 30; p_req1 = 30; p_ar = 60; p_rv = 70; p_rr = 60;
      repeat (3000) step();
      p_req0 = 70; p_req1 = 70; p_ar = 30; p_rv = 50; p_rr = 50;
      repeat (3000) step();

      // reset during the fourth beat of an 8-beat burst, then a normal request
      p_req0 = 0; p_req1 = 0; p_ar = 100; p_rv = 100; p_rr = 100;
      do_reset(2);
      M0_ARVALID = 1'b1; M0_ARADDR = 32'h0010_0000;
      base = m0_beats; guard = 0;
      while (m0_beats < base + 3 && guard < 100) begin step(); guard++; end
      if (guard >= 100) fail_now("wait_beat3_timeout");
      rst_req = 1'b1; step();
      rst_req = 1'b0; step();
      M0_ARVALID = 1'b1; M0_ARADDR = 32'h0010_0000;
      base = m0_beats; guard = 0;
      while (m0_beats < base + 8 && guard < 100) begin step(); guard++; end
      chk("post_reset_beats", 32'(m0_beats - base), 32'd8);

      // both masters saturated: M1 forced every ninth grant
      do_reset(2);
      gnt_log.delete();
      p_req0 = 100; p_req1 = 100;
      guard = 0;
      while (gnt_log.size() < 18 && guard < 1000) begin step(); guard++; end
      if (gnt_log.size() < 18) fail_now("starve_timeout");
      else for (int i = 0; i < 18; i++) chk("starve_seq", 1'(gnt_log[i]), 1'((i % 9) == 8));

      // drain and confirm every expectation was consumed
      p_req0 = 0; p_req1 = 0; p_ar = 100; p_rv = 100; p_rr = 100;
      repeat (100) step();
      chk("drain_empty", 32'(ar_q.size() + beat_q.size()), 32'd0);

`ifdef VRAMARB_STAT_EN
      @(negedge ACLK);
      chk("gnt0_cnt", GNT0_CNT, 16'(g0));
      chk("gnt1_cnt", GNT1_CNT, 16'(g1));
      STAT_CLR = 1'b1;
      step();
      STAT_CLR = 1'b0;
      @(negedge ACLK);
      chk("stat_clr", {GNT0_CNT, GNT1_CNT}, 32'd0);
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/vram_rd_arbiter.md
Name: vram_rd_arbiter

Overview:
Shares one AXI read port (address + data channels) to VRAM between two read masters. M0 is the display VRAM controller (real-time, priority); M1 is a secondary reader such as a draw/blit engine.
- Exactly one transaction outstanding at a time.
- R channel is routed back to the granted master until RLAST.
- Starvation counter guarantees M1 progress under continuous display load.

Parameters:
- DATA_W, 64, read-data width.
- STARVE_MAX, 8, consecutive M0 grants allowed while M1 waits before M1 is forced.
- CNT_W, 4, width of the starvation counter; must hold STARVE_MAX.

Ports:
- ACLK  in  1  clock
- ARST  in  1  synchronous active-high reset
- M0_ARADDR  in  32  display read address
- M0_ARVALID  in  1  display address valid
- M0_ARREADY  out  1  display address accepted
- M0_RDATA  out  DATA_W  display read data
- M0_RLAST  out  1  display last beat
- M0_RVALID  out  1  display data valid
- M0_RREADY  in  1  display data ready
- M1_ARADDR  in  32  secondary read address
- M1_ARVALID  in  1  secondary address valid
- M1_ARREADY  out  1  secondary address accepted
- M1_RDATA  out  DATA_W  secondary read data
- M1_RLAST  out  1  secondary last beat
- M1_RVALID  out  1  secondary data valid
- M1_RREADY  in  1  secondary data ready
- S_ARADDR  out  32  address to VRAM
- S_ARVALID  out  1  address valid to VRAM
- S_ARREADY  in  1  VRAM address ready
- S_RDATA  in  DATA_W  VRAM read data
- S_RLAST  in  1  VRAM last beat
- S_RVALID  in  1  VRAM data valid
- S_RREADY  out  1  ready to VRAM

Behaviour:
Clock, reset and state:
- Single clock ACLK; reset ARST synchronous, active-high.
- State machine: IDLE, ADDR, DATA (one-hot). Registers: state, owner (1 bit), starve_cnt (CNT_W).
- Reset: state=IDLE, owner=0, starve_cnt=0.
- In reset and in IDLE, all VALID/READY outputs are 0: S_ARVALID, S_RREADY, M0/M1_ARREADY, M0/M1_RVALID.

IDLE arbitration (registered; grant takes effect next cycle):
- M0_ARVALID & (!M1_ARVALID | starve_cnt<STARVE_MAX): owner=0, go to ADDR. If M1_ARVALID=1, starve_cnt+1, saturating.
- Otherwise, if M1_ARVALID: owner=1, starve_cnt=0, go to ADDR.
- Neither valid: stay in IDLE.

ADDR state:
- S_ARADDR = owner's ARADDR. In IDLE/DATA it holds the last owner's address (don't-care).
- S_ARVALID = owner's ARVALID.
- Owner's ARREADY = S_ARREADY; non-owner's ARREADY = 0.
- S_ARVALID & S_ARREADY: go to DATA.
- Owner deasserting ARVALID is tolerated: stay in ADDR.

DATA state:
- Owner's RVALID = S_RVALID, RLAST = S_RLAST, RDATA = S_RDATA. S_RREADY = owner's RREADY.
- Non-owner's RVALID = 0. Its RDATA/RLAST are driven 0.
- S_RVALID & S_RREADY & S_RLAST: go to IDLE.
- S_ARVALID and all ARREADY are 0.

Combinational-path rules:
- No combinational path S_ARREADY -> S_ARVALID. Masters may legally hold ARVALID high waiting for ARREADY.
- Accepted combinational paths, outputs from state only: S_ARREADY -> Mx_ARREADY, and Mx_RREADY <-> S_RREADY.

Latency and throughput:
- Minimum 1 idle cycle between a burst's last beat and the next AR handshake.
- Back-to-back ARs from the same master therefore take ≥3 cycles.

Boundary conditions:
- Simultaneous requests: M0 wins unless starve_cnt==STARVE_MAX.
- Reset mid-ADDR or mid-DATA: next cycle returns to IDLE and drops all handshakes. A pending VRAM burst is abandoned; the system resets VRAM side together.
- S_RVALID while in IDLE/ADDR: ignored; S_RREADY=0.

Optional Feature:
Macro VRAMARB_STAT_EN.
- Defined: adds ports STAT_CLR in 1, GNT0_CNT out 16, GNT1_CNT out 16.
  - Each counter increments on its master's AR handshake, saturating at 16'hFFFF.
  - STAT_CLR=1 clears both counters, with priority over increment.
  - ARST clears both counters.
- Undefined: ports and counters absent; all other behaviour identical.

Test Plan:
1. Reset, then M0 only: M0_ARADDR=32'h0010_0000, S_ARREADY=1, 8-beat burst -> S_ARADDR=32'h0010_0000 one cycle after request; M0 receives 8 beats; M1_RVALID=0 throughout; back to IDLE after RLAST.
2. M0 and M1 both held valid continuously, STARVE_MAX=8 -> grant sequence M0×8, M1, M0×8, M1; starve_cnt returns to 0 after each M1 grant.
3. S_ARREADY held 0 for 5 cycles in ADDR -> S_ARVALID stays 1, M0_ARREADY=0; handshake occurs on cycle 6; exactly one DATA phase follows.
4. Backpressure: M1 owner, M1_RREADY toggles 1,0,1,0 across a 4-beat burst -> S_RREADY mirrors it; all 4 beats delivered in order; no beat delivered to M0.
5. ARST asserted on beat 3 of 8 -> next cycle state=IDLE, S_RREADY=0, M0_RVALID=0; new M0 request after reset is granted normally.
6. With VRAMARB_STAT_EN: 3 M0 and 2 M1 transactions -> GNT0_CNT=3, GNT1_CNT=2; STAT_CLR pulse -> both 0 next cycle.
